// File: rtl/ysyx_ifu.sv
// ysyx_ifu: multi-cycle, non-pipelined instruction fetch unit.
// Fetches one instruction over a valid/ready read channel and hands {pc, inst}
// downstream. It then waits for the execute stage to finish and picks the
// next PC from the redirect inputs. A read error or a misaligned next PC
// parks the unit in a terminal error state until reset.
module ysyx_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        exu_done,
    input  logic        jump,
    input  logic        BrE,
    input  logic [31:0] jump_addr,
    input  logic        is_ecall,
    input  logic [31:0] mtvecdata,
    input  logic        is_mret,
    input  logic [31:0] mepcdata,
    output logic        fetch_err,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [2:0] {
        S_REQ  = 3'd0,
        S_RESP = 3'd1,
        S_HOLD = 3'd2,
        S_EXEC = 3'd3,
        S_ERR  = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        inst_valid_q, inst_valid_d;
    logic        fetch_err_q, fetch_err_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] next_pc_s;

    // Redirect priority: trap, then exception return, then jump/branch, else fall through.
    function automatic logic [31:0] select_next_pc(
        input logic [31:0] cur_pc,
        input logic        ecall_i,
        input logic [31:0] mtvec_i,
        input logic        mret_i,
        input logic [31:0] mepc_i,
        input logic        jump_i,
        input logic        bre_i,
        input logic [31:0] target_i
    );
        logic [31:0] result;
        if (ecall_i) begin
            result = mtvec_i;
        end else if (mret_i) begin
            result = mepc_i;
        end else if (jump_i || bre_i) begin
            result = target_i;
        end else begin
            result = cur_pc + 32'd4;
        end
        return result;
    endfunction

    // Instruction addresses must be word aligned.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    // Candidate next PC, only consumed in EXEC when exu_done is high.
    always_comb begin
        next_pc_s = select_next_pc(pc_q, is_ecall, mtvecdata, is_mret, mepcdata,
                                   jump, BrE, jump_addr);
    end

    // Next-state logic; handshake outputs are derived from the next state so they stay registered.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        fetch_err_d = fetch_err_q;
        fetch_cnt_d = fetch_cnt_q;
        case (state_q)
            S_REQ: begin
                if (arvalid_q && arready) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_RESP: begin
                if (rvalid) begin
                    if (rresp == 2'b00) begin
                        inst_d  = rdata;
                        state_d = S_HOLD;
                    end else begin
                        fetch_err_d = 1'b1;
                        state_d     = S_ERR;
                    end
                end else begin
                    state_d = S_RESP;
                end
            end
            S_HOLD: begin
                if (inst_ready) begin
                    fetch_cnt_d = fetch_cnt_q + 32'd1;
                    state_d     = S_EXEC;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_EXEC: begin
                if (exu_done) begin
                    // pc takes the target even when it is bad, so it is visible for debug.
                    pc_d = next_pc_s;
                    if (is_misaligned(next_pc_s)) begin
                        fetch_err_d = 1'b1;
                        state_d     = S_ERR;
                    end else begin
                        state_d = S_REQ;
                    end
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                fetch_err_d = 1'b1;
                state_d     = S_ERR;
            end
        endcase
        arvalid_d    = (state_d == S_REQ);
        rready_d     = (state_d == S_RESP);
        inst_valid_d = (state_d == S_HOLD);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            inst_q       <= 32'd0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            inst_valid_q <= 1'b0;
            fetch_err_q  <= 1'b0;
            fetch_cnt_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            inst_valid_q <= inst_valid_d;
            fetch_err_q  <= fetch_err_d;
            fetch_cnt_q  <= fetch_cnt_d;
        end
    end

    assign araddr     = pc_q;
    assign arvalid    = arvalid_q;
    assign rready     = rready_q;
    assign inst       = inst_q;
    assign pc         = pc_q;
    assign inst_valid = inst_valid_q;
    assign fetch_err  = fetch_err_q;
    assign fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_ysyx_ifu.sv
// Directed self-checking bench for ysyx_ifu.
module tb_ysyx_ifu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = 32'd0;
    logic [1:0]  rresp = 2'd0;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic        exu_done = 1'b0;
    logic        jump = 1'b0;
    logic        BrE = 1'b0;
    logic [31:0] jump_addr = 32'd0;
    logic        is_ecall = 1'b0;
    logic [31:0] mtvecdata = 32'd0;
    logic        is_mret = 1'b0;
    logic [31:0] mepcdata = 32'd0;
    logic        fetch_err;
    logic [31:0] fetch_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    ysyx_ifu #(.RESET_PC(32'h8000_0000)) dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .inst(inst), .pc(pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .exu_done(exu_done), .jump(jump), .BrE(BrE), .jump_addr(jump_addr),
        .is_ecall(is_ecall), .mtvecdata(mtvecdata), .is_mret(is_mret), .mepcdata(mepcdata),
        .fetch_err(fetch_err), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    // Advance one cycle; observe/drive 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Run one zero-wait instruction from REQ back to REQ, reporting what was seen on the way.
    task automatic do_instr(
        input  logic [31:0] data,
        input  logic        j, b, ec, mr,
        input  logic [31:0] ja, mt, me,
        output logic [31:0] o_araddr,
        output logic        o_arvalid,
        output logic        o_rready,
        output logic        o_ivalid,
        output logic [31:0] o_inst,
        output logic [31:0] o_pc
    );
        o_araddr  = araddr;
        o_arvalid = arvalid;
        arready   = 1'b1;
        tick();
        arready   = 1'b0;
        o_rready  = rready;
        rvalid    = 1'b1;
        rdata     = data;
        rresp     = 2'd0;
        tick();
        rvalid    = 1'b0;
        o_ivalid  = inst_valid;
        o_inst    = inst;
        o_pc      = pc;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        exu_done = 1'b1; jump = j; BrE = b; is_ecall = ec; is_mret = mr;
        jump_addr = ja; mtvecdata = mt; mepcdata = me;
        tick();
        exu_done = 1'b0; jump = 1'b0; BrE = 1'b0; is_ecall = 1'b0; is_mret = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++; if (pc !== 32'h8000_0000) begin n_bad++; $display("FAIL reset_pc: got %h want %h", pc, 32'h8000_0000); end
        n_cmp++; if (inst !== 32'd0) begin n_bad++; $display("FAIL reset_inst: got %h want 0", inst); end
        n_cmp++; if ({arvalid, rready, inst_valid, fetch_err} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {arvalid, rready, inst_valid, fetch_err}); end
        n_cmp++; if (fetch_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", fetch_cnt); end
        rst = 1'b0;
        tick();
        n_cmp++; if (arvalid !== 1'b1 || araddr !== 32'h8000_0000) begin n_bad++; $display("FAIL first_req: got v=%b a=%h want v=1 a=80000000", arvalid, araddr); end
    endtask

    task automatic test_sequential();
        logic [31:0] a, i, p;
        logic        av, rr, iv;
        for (int k = 0; k < 3; k++) begin
            do_instr(32'h0000_0013 + 32'(k) * 32'h100, 1'b0, 1'b0, 1'b0, 1'b0,
                     32'd0, 32'd0, 32'd0, a, av, rr, iv, i, p);
            n_cmp++; if (a !== 32'h8000_0000 + 32'(k) * 32'd4 || av !== 1'b1) begin n_bad++; $display("FAIL seq_araddr[%0d]: got v=%b a=%h want v=1 a=%h", k, av, a, 32'h8000_0000 + 32'(k) * 32'd4); end
            n_cmp++; if (rr !== 1'b1) begin n_bad++; $display("FAIL seq_rready[%0d]: got %b want 1", k, rr); end
            n_cmp++; if (iv !== 1'b1 || i !== 32'h0000_0013 + 32'(k) * 32'h100 || p !== a) begin n_bad++; $display("FAIL seq_inst[%0d]: got v=%b i=%h p=%h want v=1 i=%h p=%h", k, iv, i, p, 32'h0000_0013 + 32'(k) * 32'h100, a); end
        end
        n_cmp++; if (fetch_cnt !== 32'd3) begin n_bad++; $display("FAIL seq_cnt: got %0d want 3", fetch_cnt); end
        n_cmp++; if (araddr !== 32'h8000_000C || arvalid !== 1'b1) begin n_bad++; $display("FAIL seq_next: got v=%b a=%h want v=1 a=8000000c", arvalid, araddr); end
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 5; k++) begin
            arready = 1'b0;
            tick();
            n_cmp++; if (arvalid !== 1'b1 || araddr !== 32'h8000_000C) begin n_bad++; $display("FAIL bp_ar[%0d]: got v=%b a=%h want v=1 a=8000000c", k, arvalid, araddr); end
        end
        // Data offered in the handshake cycle must be ignored.
        arready = 1'b1; rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
        tick();
        arready = 1'b0; rvalid = 1'b0;
        n_cmp++; if (rready !== 1'b1 || inst_valid !== 1'b0 || arvalid !== 1'b0) begin n_bad++; $display("FAIL bp_early_rvalid: got rr=%b iv=%b av=%b want 1 0 0", rready, inst_valid, arvalid); end
        tick();
        n_cmp++; if (rready !== 1'b1 || inst_valid !== 1'b0) begin n_bad++; $display("FAIL bp_resp_wait: got rr=%b iv=%b want 1 0", rready, inst_valid); end
        rvalid = 1'b1; rdata = 32'h1234_5678;
        tick();
        rvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (inst_valid !== 1'b1 || inst !== 32'h1234_5678 || pc !== 32'h8000_000C || fetch_cnt !== 32'd3) begin n_bad++; $display("FAIL bp_hold[%0d]: got iv=%b i=%h p=%h c=%0d want 1 12345678 8000000c 3", k, inst_valid, inst, pc, fetch_cnt); end
            tick();
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        n_cmp++; if (inst_valid !== 1'b0 || fetch_cnt !== 32'd4) begin n_bad++; $display("FAIL bp_accept: got iv=%b c=%0d want 0 4", inst_valid, fetch_cnt); end
        // Redirects without exu_done are ignored.
        jump = 1'b1; is_ecall = 1'b1; jump_addr = 32'h0000_1000; mtvecdata = 32'h0000_2000;
        tick();
        tick();
        n_cmp++; if (arvalid !== 1'b0 || pc !== 32'h8000_000C || inst !== 32'h1234_5678) begin n_bad++; $display("FAIL bp_exec_wait: got av=%b p=%h i=%h want 0 8000000c 12345678", arvalid, pc, inst); end
        jump = 1'b0; is_ecall = 1'b0; exu_done = 1'b1;
        tick();
        exu_done = 1'b0;
        n_cmp++; if (arvalid !== 1'b1 || araddr !== 32'h8000_0010 || fetch_cnt !== 32'd4) begin n_bad++; $display("FAIL bp_next: got v=%b a=%h c=%0d want 1 80000010 4", arvalid, araddr, fetch_cnt); end
    endtask

    task automatic test_redirects();
        logic [31:0] a, i, p;
        logic        av, rr, iv;
        do_instr(32'h0000_0063, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0100, 32'd0, 32'd0, a, av, rr, iv, i, p);
        n_cmp++; if (araddr !== 32'h8000_0100) begin n_bad++; $display("FAIL redir_bre: got %h want 80000100", araddr); end
        do_instr(32'h0000_0073, 1'b1, 1'b0, 1'b1, 1'b0, 32'h8000_0300, 32'h8000_0200, 32'd0, a, av, rr, iv, i, p);
        n_cmp++; if (araddr !== 32'h8000_0200) begin n_bad++; $display("FAIL redir_ecall_over_jump: got %h want 80000200", araddr); end
        do_instr(32'h3020_0073, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0300, 32'd0, 32'h8000_0010, a, av, rr, iv, i, p);
        n_cmp++; if (araddr !== 32'h8000_0010) begin n_bad++; $display("FAIL redir_mret: got %h want 80000010", araddr); end
    endtask

    task automatic test_wrap();
        logic [31:0] a, i, p;
        logic        av, rr, iv;
        do_instr(32'h0000_006F, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'd0, 32'd0, a, av, rr, iv, i, p);
        n_cmp++; if (araddr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_jump: got %h want fffffffc", araddr); end
        do_instr(32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, a, av, rr, iv, i, p);
        n_cmp++; if (araddr !== 32'h0000_0000 || arvalid !== 1'b1 || fetch_err !== 1'b0) begin n_bad++; $display("FAIL wrap_seq: got a=%h v=%b e=%b want 0 1 0", araddr, arvalid, fetch_err); end
    endtask

    task automatic test_errors();
        logic [31:0] a, i, p;
        logic        av, rr, iv;
        apply_reset();
        arready = 1'b1;
        tick();
        arready = 1'b0; rvalid = 1'b1; rresp = 2'd2; rdata = 32'h0BAD_0BAD;
        tick();
        rvalid = 1'b0; rresp = 2'd0;
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (fetch_err !== 1'b1 || inst_valid !== 1'b0 || arvalid !== 1'b0 || rready !== 1'b0) begin n_bad++; $display("FAIL err_rresp[%0d]: got e=%b iv=%b av=%b rr=%b want 1 0 0 0", k, fetch_err, inst_valid, arvalid, rready); end
            arready = 1'b1; inst_ready = 1'b1;
            tick();
        end
        arready = 1'b0; inst_ready = 1'b0;
        apply_reset();
        n_cmp++; if (fetch_err !== 1'b0 || arvalid !== 1'b1) begin n_bad++; $display("FAIL err_cleared: got e=%b av=%b want 0 1", fetch_err, arvalid); end
        do_instr(32'h0000_006F, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0102, 32'd0, 32'd0, a, av, rr, iv, i, p);
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (fetch_err !== 1'b1 || pc !== 32'h8000_0102 || arvalid !== 1'b0 || fetch_cnt !== 32'd1) begin n_bad++; $display("FAIL err_misalign[%0d]: got e=%b p=%h av=%b c=%0d want 1 80000102 0 1", k, fetch_err, pc, arvalid, fetch_cnt); end
            tick();
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] a, i, p;
        logic        av, rr, iv;
        apply_reset();
        do_instr(32'h1111_2222, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, a, av, rr, iv, i, p);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'hAAAA_5555; rst = 1'b1;
        tick();
        rvalid = 1'b0;
        n_cmp++; if (inst !== 32'd0 || pc !== 32'h8000_0000 || fetch_cnt !== 32'd0) begin n_bad++; $display("FAIL midrst_state: got i=%h p=%h c=%0d want 0 80000000 0", inst, pc, fetch_cnt); end
        n_cmp++; if ({arvalid, rready, inst_valid} !== 3'b000) begin n_bad++; $display("FAIL midrst_valids: got %b want 000", {arvalid, rready, inst_valid}); end
        rst = 1'b0;
        tick();
        n_cmp++; if (arvalid !== 1'b1 || araddr !== 32'h8000_0000 || inst !== 32'd0) begin n_bad++; $display("FAIL midrst_restart: got v=%b a=%h i=%h want 1 80000000 0", arvalid, araddr, inst); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirects();
        test_wrap();
        test_errors();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_ifu.md
# ysyx_ifu

Multi-cycle instruction fetch unit feeding the decode/execute path. Holds the architectural PC, fetches one instruction at a time over a valid/ready read channel, and presents `{pc, inst}` downstream with a valid/ready handshake. The unit then waits for the execute stage to report completion and selects the next PC from that stage's redirect outputs: branch/jump target, trap vector or exception return. One instruction is in flight at a time; the unit is not pipelined.

## Interface
- `RESET_PC`, default 32'h8000_0000, PC loaded on reset.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `araddr` out 32: fetch address.
- `arvalid` out 1: fetch request valid.
- `arready` in 1: memory accepts request.
- `rdata` in 32: fetched instruction word.
- `rresp` in 2: 0 = OK; any nonzero value = error.
- `rvalid` in 1: read data valid.
- `rready` out 1: IFU accepts read data.
- `inst` out 32: instruction to decode.
- `pc` out 32: PC of `inst`.
- `inst_valid` out 1: `{pc, inst}` valid.
- `inst_ready` in 1: downstream accepts instruction.
- `exu_done` in 1: execute stage finished the current instruction; redirect inputs are valid this cycle.
- `jump` in 1: unconditional jump (jal/jalr).
- `BrE` in 1: conditional branch taken.
- `jump_addr` in 32: target for `jump` or `BrE`.
- `is_ecall` in 1: trap; go to `mtvecdata`.
- `mtvecdata` in 32: trap vector.
- `is_mret` in 1: return; go to `mepcdata`.
- `mepcdata` in 32: return address.
- `fetch_err` out 1: sticky error flag.
- `fetch_cnt` out 32: count of instructions handed downstream.

## Operation
- FSM states:
  - `REQ`: `arvalid`=1, `araddr`=`pc`. Goes to `RESP` on `arvalid&&arready`.
  - `RESP`: `rready`=1. On `rvalid`:
    - `rresp`==0: latch `inst`<=`rdata`, go to `HOLD`.
    - otherwise: set `fetch_err`, go to `ERR`.
  - `HOLD`: `inst_valid`=1. On `inst_ready`: increment `fetch_cnt`, go to `EXEC`.
  - `EXEC`: wait for `exu_done`. When it is seen, register next PC and go to `REQ`.
  - `ERR`: terminal. All valids deasserted. Exit only via `rst`.
- Next-PC priority, highest first: `is_ecall` -> `mtvecdata`; `is_mret` -> `mepcdata`; `jump|BrE` -> `jump_addr`; otherwise `pc+4`. Addition is 32-bit modulo; 32'hFFFF_FFFC+4 = 0.
- Misalignment: a selected next PC with `[1:0]`!=0 sets `fetch_err` and goes to `ERR`. `pc` still updates to the bad value for debug.
- Redirect inputs are ignored outside `EXEC` or when `exu_done`=0.
- `araddr` and `arvalid` stay stable from assertion until the handshake. They must not depend combinationally on `arready`.
- `pc` and `inst` stay stable while `inst_valid`=1 and through `EXEC`.
- `fetch_cnt` wraps from 32'hFFFF_FFFF to 0.

## Timing
- Reset values: `pc`=`RESET_PC`, `inst`=0, `arvalid`=0, `rready`=0, `inst_valid`=0, `fetch_err`=0, `fetch_cnt`=0, state=`REQ`. `arvalid` rises the first cycle after `rst` is deasserted.
- Best case with zero-wait memory: request at cycle N, data at N+1, `inst_valid` at N+2. With `inst_ready`=1, enter `EXEC` at N+3. With `exu_done` at N+3, next `arvalid` at N+4. Result: 4 cycles per instruction plus execute latency.
- `rvalid` arriving in the same cycle as the `arready` handshake is not accepted; `rready` is only high in `RESP`.
- `rst` mid-operation (any state) aborts the cycle. All outputs return to reset values on the next edge. An outstanding memory response is dropped: `rready`=0.
- `exu_done` together with `is_ecall` and `jump`: ecall wins.
- `fetch_err` and `ERR` persist until `rst`.

## Test plan
- Reset/sequential: `RESET_PC`=32'h8000_0000, memory has 1-cycle latency, `jump`/`BrE`=0 -> `araddr` sequence 8000_0000, 8000_0004, 8000_0008; `fetch_cnt`=3 after the third `inst_ready`.
- Backpressure: hold `arready`=0 for 5 cycles, then `inst_ready`=0 for 4 cycles -> `araddr`/`arvalid` stable throughout; `inst`/`pc` stable; no extra count.
- Redirects: at `exu_done`, drive `BrE`=1 with `jump_addr`=8000_0100 -> next `araddr`=8000_0100. Then `is_ecall`=1 and `jump`=1 with `mtvecdata`=8000_0200 -> 8000_0200. Then `is_mret` with `mepcdata`=8000_0010 -> 8000_0010.
- Errors: `rresp`=2 -> `fetch_err`=1, `inst_valid` never rises, `arvalid` stays 0. Separately, `jump_addr`=8000_0102 with `jump`=1 -> `fetch_err`=1.
- Mid-op reset: assert `rst` in `RESP` while `rvalid`=1 -> data not latched; next cycle `pc`=8000_0000, all valids 0, `fetch_cnt`=0.
- Wrap: start at 32'hFFFF_FFFC with a sequential next PC -> next `araddr`=0.
